// File: rtl/vga_sync_decoder.sv
// Recovers column/row position and frame timing from active-region sync inputs,
// measures the frame geometry and reports lock once two consecutive frames agree.
module vga_sync_decoder #(
    parameter int COUNT_WIDTH = 10
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [COUNT_WIDTH-1:0] o_Col_Count,
    output logic [COUNT_WIDTH-1:0] o_Row_Count,
    output logic                   o_Frame_Start,
    output logic                   o_Locked,
    output logic [COUNT_WIDTH-1:0] o_Total_Cols,
    output logic [COUNT_WIDTH-1:0] o_Active_Cols,
    output logic [COUNT_WIDTH-1:0] o_Total_Rows,
    output logic [COUNT_WIDTH-1:0] o_Active_Rows,
    output logic [1:0]             o_State
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t state, state_next;

    logic                   h_prev, v_prev;
    logic                   h_edge, v_edge;
    logic [COUNT_WIDTH-1:0] line_cnt, act_cnt;
    logic [COUNT_WIDTH-1:0] ref_len, ref_act;
    logic                   have_ref, line_mismatch;
    logic [COUNT_WIDTH-1:0] rows_cnt, act_rows;
    logic                   timeout, line_differs, mismatch_eff;
    logic [COUNT_WIDTH-1:0] cap_cols, cap_act_cols;
    logic                   cap_valid, cap_equal;
    logic                   prev_valid, prev_valid_next, capture;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + COUNT_WIDTH'(1);
    endfunction

    assign h_edge  = i_HSync & ~h_prev;
    assign v_edge  = i_VSync & ~v_prev;
    assign timeout = (line_cnt == CNT_MAX);

    // The line closing at a V edge still belongs to the frame being captured.
    assign line_differs = (line_cnt != ref_len) || (act_cnt != ref_act);
    assign mismatch_eff = line_mismatch | (have_ref & h_edge & line_differs);

    assign cap_cols     = have_ref ? ref_len : '0;
    assign cap_act_cols = have_ref ? ref_act : '0;
    assign cap_valid    = (cap_cols != '0) && (cap_act_cols != '0) && (rows_cnt != '0) &&
                          (act_rows != '0) && !mismatch_eff;
    // The measurement outputs always hold the previous capture.
    assign cap_equal    = (cap_cols == o_Total_Cols) && (cap_act_cols == o_Active_Cols) &&
                          (rows_cnt == o_Total_Rows) && (act_rows == o_Active_Rows);

    assign o_State = state;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            h_prev        <= 1'b1;
            v_prev        <= 1'b1;
            o_HSync       <= 1'b0;
            o_VSync       <= 1'b0;
            o_Col_Count   <= '0;
            o_Row_Count   <= '0;
            o_Frame_Start <= 1'b0;
            line_cnt      <= '0;
            act_cnt       <= '0;
            ref_len       <= '0;
            ref_act       <= '0;
            have_ref      <= 1'b0;
            line_mismatch <= 1'b0;
            rows_cnt      <= '0;
            act_rows      <= '0;
        end else begin
            h_prev        <= i_HSync;
            v_prev        <= i_VSync;
            o_HSync       <= i_HSync;
            o_VSync       <= i_VSync;
            o_Col_Count   <= h_edge ? '0 : sat_inc(o_Col_Count);
            o_Frame_Start <= v_edge;
            if (v_edge) begin
                o_Row_Count <= '0;
            end else if (h_edge) begin
                o_Row_Count <= sat_inc(o_Row_Count);
            end

            if (h_edge) begin
                line_cnt <= COUNT_WIDTH'(1);
                act_cnt  <= COUNT_WIDTH'(1);
            end else begin
                line_cnt <= sat_inc(line_cnt);
                if (i_HSync) begin
                    act_cnt <= sat_inc(act_cnt);
                end
            end

            // Frame counters restart at every V edge, counting the coincident H edge.
            if (v_edge) begin
                rows_cnt      <= {{(COUNT_WIDTH-1){1'b0}}, h_edge};
                act_rows      <= {{(COUNT_WIDTH-1){1'b0}}, h_edge};
                have_ref      <= 1'b0;
                line_mismatch <= 1'b0;
            end else if (h_edge) begin
                rows_cnt <= sat_inc(rows_cnt);
                if (i_VSync) begin
                    act_rows <= sat_inc(act_rows);
                end
                if (!have_ref) begin
                    ref_len  <= line_cnt;
                    ref_act  <= act_cnt;
                    have_ref <= 1'b1;
                end else if (line_differs) begin
                    line_mismatch <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next      = state;
        prev_valid_next = prev_valid;
        capture         = 1'b0;
        case (state)
            SEARCH: begin
                if (v_edge) state_next = MEASURE;
            end
            MEASURE: begin
                if (v_edge) begin
                    capture = 1'b1;
                    if (cap_valid && prev_valid && cap_equal) begin
                        state_next = LOCKED;
                    end else begin
                        prev_valid_next = cap_valid;
                    end
                end
            end
            LOCKED: begin
                if (v_edge) begin
                    capture = 1'b1;
                    if (!(cap_valid && cap_equal)) begin
                        state_next      = MEASURE;
                        prev_valid_next = 1'b0;
                    end
                end
            end
            default: state_next = SEARCH;
        endcase
        // A stalled line overrides everything, including a simultaneous V edge.
        if (timeout) begin
            state_next      = SEARCH;
            prev_valid_next = 1'b0;
            capture         = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state         <= SEARCH;
            prev_valid    <= 1'b0;
            o_Locked      <= 1'b0;
            o_Total_Cols  <= '0;
            o_Active_Cols <= '0;
            o_Total_Rows  <= '0;
            o_Active_Rows <= '0;
        end else begin
            state      <= state_next;
            prev_valid <= prev_valid_next;
            o_Locked   <= (state_next == LOCKED);
            if (capture) begin
                o_Total_Cols  <= cap_cols;
                o_Active_Cols <= cap_act_cols;
                o_Total_Rows  <= rows_cnt;
                o_Active_Rows <= act_rows;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: drives a parameterised upstream raster generator
// and compares every output against expectations derived from the raster itself.
module tb_vga_sync_decoder;

    localparam int W = 10;
    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         hs, vs;
    logic         o_hs, o_vs, o_fs, o_lock;
    logic [W-1:0] o_col, o_row, o_tc, o_ac, o_tr, o_ar;
    logic [1:0]   o_state;

    vga_sync_decoder #(.COUNT_WIDTH(W)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_HSync(hs), .i_VSync(vs),
        .o_HSync(o_hs), .o_VSync(o_vs), .o_Col_Count(o_col), .o_Row_Count(o_row),
        .o_Frame_Start(o_fs), .o_Locked(o_lock),
        .o_Total_Cols(o_tc), .o_Active_Cols(o_ac), .o_Total_Rows(o_tr), .o_Active_Rows(o_ar),
        .o_State(o_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Upstream raster generator.
    int tc, ac, tr, ar;
    int gcol, grow;
    int long_row = -1;
    bit force_low, dist_done;

    // Reference observations.
    bit mv_prev, exp_fs, s_h, s_v, check_align;
    int s_col, s_row, tick_no, last_fs_tick;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        hs = !force_low && (gcol < ac);
        vs = !force_low && (grow < ar);
    endtask

    task automatic advance();
        int len;
        len = tc + ((grow == long_row) ? 1 : 0);
        gcol++;
        if (gcol >= len) begin
            gcol = 0;
            if (grow == long_row) begin
                long_row  = -1;
                dist_done = 1'b1;
            end
            grow = (grow + 1 == tr) ? 0 : grow + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tick_no++;
        s_h = hs; s_v = vs; s_col = gcol; s_row = grow;
        exp_fs  = s_v && !mv_prev;
        mv_prev = s_v;
        chk("hsync_delay", o_hs, s_h);
        chk("vsync_delay", o_vs, s_v);
        if (check_align) begin
            chk("col_align", o_col, s_col);
            chk("row_align", o_row, s_row);
            chk("frame_start", o_fs, exp_fs);
            if (exp_fs) begin
                if (last_fs_tick >= 0) chk("frame_period", tick_no - last_fs_tick, tc * tr);
                last_fs_tick = tick_no;
            end
        end
        advance();
        drive();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_hs"}, o_hs, 0);   chk({tag, "_vs"}, o_vs, 0);
        chk({tag, "_col"}, o_col, 0); chk({tag, "_row"}, o_row, 0);
        chk({tag, "_fs"}, o_fs, 0);   chk({tag, "_lock"}, o_lock, 0);
        chk({tag, "_tc"}, o_tc, 0);   chk({tag, "_ac"}, o_ac, 0);
        chk({tag, "_tr"}, o_tr, 0);   chk({tag, "_ar"}, o_ar, 0);
        chk({tag, "_state"}, o_state, ST_SEARCH);
    endtask

    task automatic check_meas(input string tag);
        exp_q.push_back(W'(tc)); exp_q.push_back(W'(ac));
        exp_q.push_back(W'(tr)); exp_q.push_back(W'(ar));
        chk({tag, "_total_cols"}, o_tc, exp_q.pop_front());
        chk({tag, "_active_cols"}, o_ac, exp_q.pop_front());
        chk({tag, "_total_rows"}, o_tr, exp_q.pop_front());
        chk({tag, "_active_rows"}, o_ar, exp_q.pop_front());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        gcol = 0; grow = 0; long_row = -1; force_low = 1'b0; check_align = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        mv_prev = 1'b1;
        last_fs_tick = -1;
    endtask

    task automatic wait_vedge(input string tag);
        int i;
        for (i = 0; i < 4 * tc * tr && !exp_fs; i++) tick();
        if (!exp_fs) chk({tag, "_vedge_timeout"}, 0, 1);
    endtask

    // Lock must appear exactly at the third V edge after reset release.
    task automatic lock_seq(input string tag);
        int k = 0;
        for (int i = 0; i < 5 * tc * tr + 10 && k < 3; i++) begin
            tick();
            if (exp_fs) begin
                k++;
                chk({tag, "_lock_at_edge"}, o_lock, (k >= 3));
                if (k == 2) chk({tag, "_state_measure"}, o_state, ST_MEASURE);
            end
        end
        if (k < 3) chk({tag, "_lock_timeout"}, k, 3);
        check_meas(tag);
    endtask

    initial begin
        tick_no = 0; last_fs_tick = -1; dist_done = 1'b0; exp_fs = 1'b0;
        tc = 10; ac = 8; tr = 6; ar = 4;
        rst_n = 1'b0; gcol = 0; grow = 0; force_low = 1'b0; drive();
        #1;
        check_zero("por");

        // Steady lock on the 10/6/8/4 raster, then alignment over ten frames.
        do_reset();
        lock_seq("steady");
        check_align = 1'b1;
        repeat (600) tick();
        check_align = 1'b0;
        chk("steady_still_locked", o_lock, 1);

        // One lengthened line drops lock at the next V edge; two clean frames relock.
        tick();
        exp_fs = 1'b0;
        dist_done = 1'b0;
        long_row = $urandom_range(0, tr - 1);
        for (int i = 0; i < 4 * tc * tr && !dist_done; i++) tick();
        chk("dist_line_done", dist_done, 1);
        exp_fs = 1'b0;
        wait_vedge("dist1");
        chk("dist_lock_dropped", o_lock, 0);
        chk("dist_state", o_state, ST_MEASURE);
        tick();
        wait_vedge("dist2");
        chk("dist_lock_clean1", o_lock, 0);
        tick();
        wait_vedge("dist3");
        chk("dist_relock", o_lock, 1);
        check_meas("dist");

        // Timeout: both syncs held low from a line start.
        for (int i = 0; i < 2 * tc && gcol != 0; i++) tick();
        force_low = 1'b1;
        drive();
        repeat (900) tick();
        chk("timeout_not_yet", o_lock, 1);
        repeat (123) tick();
        chk("timeout_lock", o_lock, 0);
        chk("timeout_state", o_state, ST_SEARCH);
        chk("timeout_col_sat", o_col, 1023);
        check_meas("timeout");
        force_low = 1'b0;
        drive();

        // Mid-line reset clears everything at once, then relock from scratch.
        repeat ($urandom_range(3, 50)) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        do_reset();
        lock_seq("rst_relock");

        // Randomised raster geometries.
        for (int n = 0; n < 3; n++) begin
            tc = $urandom_range(6, 16);
            ac = $urandom_range(2, tc - 1);
            tr = $urandom_range(3, 8);
            ar = $urandom_range(1, tr - 1);
            do_reset();
            lock_seq("rand");
            check_align = 1'b1;
            repeat (3 * tc * tr) tick();
            check_align = 1'b0;
            chk("rand_still_locked", o_lock, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 10; width of all count and measurement outputs.
REQ-002 SHALL have port i_Clk, input, 1 bit; the single clock, rising-edge.
REQ-003 SHALL have port i_Rst_L, input, 1 bit; asynchronous active-low reset.
REQ-004 SHALL have port i_HSync, input, 1 bit; high while the upstream column is below the active column count.
REQ-005 SHALL have port i_VSync, input, 1 bit; high while the upstream row is below the active row count.
REQ-006 SHALL have ports o_HSync and o_VSync, outputs, 1 bit each; i_HSync and i_VSync delayed by one clock.
REQ-007 SHALL have ports o_Col_Count and o_Row_Count, outputs, COUNT_WIDTH bits each; recovered column and row, aligned to o_HSync and o_VSync.
REQ-008 SHALL have port o_Frame_Start, output, 1 bit; one-cycle pulse aligned with o_Col_Count=0 and o_Row_Count=0.
REQ-009 SHALL have port o_Locked, output, 1 bit; high while the measured timing is stable.
REQ-010 SHALL have ports o_Total_Cols, o_Active_Cols, o_Total_Rows and o_Active_Rows, outputs, COUNT_WIDTH bits each; last captured frame measurement.

Function
REQ-011 SHALL define an H edge as i_HSync=1 with the previous sample 0, and a V edge as i_VSync=1 with the previous sample 0; the edge-detect register SHALL reset to 1, so no edge is detected immediately after reset.
REQ-012 SHALL, on an H edge, load o_Col_Count with 0; otherwise it SHALL increment o_Col_Count, saturating at all-ones.
REQ-013 SHALL, on a V edge, load o_Row_Count with 0 (V edge takes precedence over H edge); on an H edge without a V edge it SHALL increment o_Row_Count, saturating at all-ones.
REQ-014 SHALL assert o_Frame_Start for exactly the cycle after a V edge sample.
REQ-015 SHALL keep running per-line counters: line length = cycles between consecutive H edges; active length = cycles i_HSync is sampled high in that line.
REQ-016 SHALL set a line_mismatch flag for the current frame when a line's length or active length differs from the first line of the same frame.
REQ-017 SHALL keep per-frame counters: total rows = H edges from one V edge up to but excluding the next V edge; active rows = H edges sampled while i_VSync=1, including the edge coincident with the V edge.
REQ-018 SHALL implement the states SEARCH, MEASURE and LOCKED, with SEARCH as the reset state.
REQ-019 SHALL transition SEARCH -> MEASURE on a V edge and clear the frame counters and line_mismatch.
REQ-020 SHALL, in MEASURE at a V edge, capture the frame measurement into the o_Total_*/o_Active_* outputs; if the capture is valid (all four values nonzero, line_mismatch=0) and equals the previous valid capture, the state SHALL become LOCKED; otherwise it SHALL stay MEASURE and store the capture as the previous capture.
REQ-021 SHALL, in LOCKED at a V edge, capture again; on any difference or line_mismatch=1 it SHALL go to MEASURE and invalidate the previous capture.
REQ-022 SHALL drive o_Locked=1 exactly while in LOCKED, registered, and rising one cycle after the qualifying V edge sample.
REQ-023 SHALL force SEARCH when the cycles since the last H edge reach 2^COUNT_WIDTH-1; this SHALL clear o_Locked, invalidate the previous capture, and hold the measurement outputs at their last values.
REQ-024 SHALL, on a simultaneous timeout and V edge, let the timeout win.

Reset
REQ-025 SHALL, while i_Rst_L=0, asynchronously hold these values:
- o_HSync=0, o_VSync=0;
- o_Col_Count=0, o_Row_Count=0;
- o_Frame_Start=0, o_Locked=0;
- all measurement outputs 0;
- previous capture invalid, state SEARCH.
REQ-026 SHALL, when reset is asserted mid-frame, discard all partial counts; after release it SHALL restart from SEARCH.

Verification
REQ-027 SHALL verify steady lock: an upstream generator with 10/6/8/4 total cols/rows and active cols/rows gives o_Total_Cols=10, o_Active_Cols=8, o_Total_Rows=6, o_Active_Rows=4, with o_Locked rising one cycle after the third V edge.
REQ-028 SHALL verify alignment: once locked, o_Col_Count and o_Row_Count equal the generator's col and row delayed one cycle; o_Frame_Start pulses once per 60 cycles.
REQ-029 SHALL verify line disturbance: lengthening one line to 11 cycles while locked drops o_Locked at the next V edge, and lock regains after two further clean frames.
REQ-030 SHALL verify timeout: holding both syncs low for 1023 cycles while locked gives o_Locked=0 and state SEARCH, with measurement outputs unchanged.
REQ-031 SHALL verify reset: asserting i_Rst_L=0 mid-line clears every output to 0 immediately; after release the block relocks after three V edges.
